// File: rtl/stb_drain_arb.sv
// stb_drain_arb: per-thread store-buffer occupancy tracking and credit-limited
// round-robin drain of pending stores onto the single PCX store-request port.
module stb_drain_arb #(
  parameter int NENT    = 8,
  parameter int CREDITS = 2
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic [3:0] stb_alloc,
  input  logic [3:0] stb_flush,
  input  logic       pcx_gnt,
  input  logic       pcx_ack,
  input  logic [1:0] pcx_ack_tid,
  output logic       pcx_req,
  output logic [1:0] pcx_req_tid,
  output logic [3:0] stbcnt0,
  output logic [3:0] stbcnt1,
  output logic [3:0] stbcnt2,
  output logic [3:0] stbcnt3,
  output logic [3:0] stb_full,
  output logic       stb_err
);
  localparam logic [3:0] FULL = 4'(NENT);
  localparam logic [1:0] CRED = 2'(CREDITS);
  logic [3:0][3:0] cnt_q, cnt_d, iss_q, iss_d;
  logic [1:0] cred_q, cred_d, cred_p, last_q, last_d, tid_q, tid_d, sel, idx;
  logic req_q, req_d, err_q, err_d, gnt, ack_ok, found, hold, load;
  logic [3:0] gv, av, ovf, avail;
  always_comb begin
    gnt = req_q && pcx_gnt;
    ack_ok = pcx_ack && iss_q[pcx_ack_tid] != '0;
    cred_p = cred_q + 2'(gnt);
    cred_d = cred_p - 2'(ack_ok);
    last_d = gnt ? tid_q : last_q;
    gv = '0;
    av = '0;
    ovf = '0;
    avail = '0;
    iss_d = iss_q;
    cnt_d = cnt_q;
    for (int t = 0; t < 4; t++) begin
      gv[t] = gnt && tid_q == 2'(t);
      av[t] = ack_ok && pcx_ack_tid == 2'(t);
      ovf[t] = stb_alloc[t] && cnt_q[t] == FULL && !av[t];
      iss_d[t] = iss_q[t] + 4'(gv[t]) - 4'(av[t]);
      // a flush keeps only issued entries, so the count collapses onto iss
      cnt_d[t] = stb_flush[t] ? iss_d[t] : cnt_q[t] + 4'(stb_alloc[t] && !ovf[t]) - 4'(av[t]);
      avail[t] = !stb_flush[t] && cnt_q[t] - iss_q[t] - 4'(gv[t]) != '0;
    end
    err_d = err_q || (pcx_ack && !ack_ok) || ovf != '0;
    found = 1'b0;
    sel = last_d;
    idx = last_d;
    for (int i = 1; i <= 4; i++) begin
      idx = last_d + 2'(i);
      if (!found && avail[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
    hold = req_q && !pcx_gnt;
    load = found && cred_p < CRED;
    req_d = hold ? !stb_flush[tid_q] : load;
    tid_d = hold ? tid_q : load ? sel : tid_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      cnt_q <= '0;
      iss_q <= '0;
      cred_q <= '0;
      last_q <= 2'd3;
      tid_q <= '0;
      req_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      iss_q <= iss_d;
      cred_q <= cred_d;
      last_q <= last_d;
      tid_q <= tid_d;
      req_q <= req_d;
      err_q <= err_d;
    end
  end
  assign pcx_req = req_q;
  assign pcx_req_tid = tid_q;
  assign stbcnt0 = cnt_q[0];
  assign stbcnt1 = cnt_q[1];
  assign stbcnt2 = cnt_q[2];
  assign stbcnt3 = cnt_q[3];
  assign stb_full = {cnt_q[3] == FULL, cnt_q[2] == FULL, cnt_q[1] == FULL, cnt_q[0] == FULL};
  assign stb_err = err_q;
endmodule

// File: tb/tb_stb_drain_arb.sv
// tb_stb_drain_arb: directed scenario tests for the store-buffer drain arbiter.
module tb_stb_drain_arb;
  logic clk = 1'b0, rst_l = 1'b0;
  logic [3:0] stb_alloc = '0, stb_flush = '0;
  logic pcx_gnt = 1'b0, pcx_ack = 1'b0;
  logic [1:0] pcx_ack_tid = '0;
  logic pcx_req, stb_err;
  logic [1:0] pcx_req_tid;
  logic [3:0] stbcnt0, stbcnt1, stbcnt2, stbcnt3, stb_full;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  stb_drain_arb dut (
    .clk(clk), .rst_l(rst_l), .stb_alloc(stb_alloc), .stb_flush(stb_flush),
    .pcx_gnt(pcx_gnt), .pcx_ack(pcx_ack), .pcx_ack_tid(pcx_ack_tid),
    .pcx_req(pcx_req), .pcx_req_tid(pcx_req_tid),
    .stbcnt0(stbcnt0), .stbcnt1(stbcnt1), .stbcnt2(stbcnt2), .stbcnt3(stbcnt3),
    .stb_full(stb_full), .stb_err(stb_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    stb_alloc = '0;
    stb_flush = '0;
    pcx_gnt = 1'b0;
    pcx_ack = 1'b0;
    pcx_ack_tid = '0;
  endtask

  task automatic test_reset;
    idle;
    rst_l = 1'b0;
    tick;
    rst_l = 1'b1;
    checks++;
    if ({pcx_req, pcx_req_tid, stbcnt0, stbcnt1, stbcnt2, stbcnt3, stb_full, stb_err} !== 24'h0) begin
      errors++;
      $display("FAIL reset: outputs=%h expected 0", {pcx_req, pcx_req_tid, stbcnt0, stbcnt1, stbcnt2, stbcnt3, stb_full, stb_err});
    end
  endtask

  task automatic test_single;
    int exp_cnt[9] = '{1, 2, 3, 3, 2, 1, 1, 1, 0};
    bit exp_req[9] = '{0, 1, 1, 0, 0, 1, 0, 0, 0};
    bit g1 = 0, g2 = 0;
    int ngr = 0;
    for (int k = 0; k < 9; k++) begin
      stb_alloc = (k < 3) ? 4'b0100 : 4'b0000;
      pcx_gnt = pcx_req;
      pcx_ack = g2;
      pcx_ack_tid = 2'd2;
      if (pcx_gnt && pcx_req_tid == 2'd2) ngr++;
      g2 = g1;
      g1 = pcx_gnt;
      tick;
      checks++;
      if (stbcnt2 !== 4'(exp_cnt[k])) begin errors++; $display("FAIL single_cnt[%0d]: got %0d expected %0d", k, stbcnt2, exp_cnt[k]); end
      checks++;
      if (pcx_req !== exp_req[k]) begin errors++; $display("FAIL single_req[%0d]: got %0d expected %0d", k, pcx_req, exp_req[k]); end
    end
    idle;
    checks++;
    if (ngr !== 3) begin errors++; $display("FAIL single_grants: got %0d expected 3", ngr); end
  endtask

  task automatic test_fairness;
    int n = 0;
    bit pg = 0;
    logic [1:0] pt = '0;
    test_reset;
    stb_alloc = 4'hf;
    repeat (4) tick;
    stb_alloc = '0;
    checks++;
    if ({stbcnt3, stbcnt2, stbcnt1, stbcnt0} !== 16'h4444) begin errors++; $display("FAIL fair_fill: got %h expected 4444", {stbcnt3, stbcnt2, stbcnt1, stbcnt0}); end
    for (int k = 0; k < 80 && n < 16; k++) begin
      pcx_gnt = 1'b1;
      pcx_ack = pg;
      pcx_ack_tid = pt;
      pg = pcx_req;
      pt = pcx_req_tid;
      if (pcx_req) begin
        checks++;
        if (pcx_req_tid !== 2'(n % 4)) begin errors++; $display("FAIL fair_order[%0d]: got %0d expected %0d", n, pcx_req_tid, n % 4); end
        n++;
      end
      tick;
    end
    pcx_gnt = 1'b0;
    pcx_ack = pg;
    pcx_ack_tid = pt;
    tick;
    idle;
    checks++;
    if (n !== 16) begin errors++; $display("FAIL fair_count: got %0d grants expected 16 within budget", n); end
    checks++;
    if ({stbcnt3, stbcnt2, stbcnt1, stbcnt0, pcx_req} !== 17'h0) begin errors++; $display("FAIL fair_drain: got %h expected 0", {stbcnt3, stbcnt2, stbcnt1, stbcnt0, pcx_req}); end
  endtask

  task automatic test_credit;
    int ng = 0;
    test_reset;
    stb_alloc = 4'b0001;
    repeat (5) tick;
    stb_alloc = '0;
    repeat (6) begin
      pcx_gnt = pcx_req;
      if (pcx_req) ng++;
      tick;
    end
    pcx_gnt = 1'b0;
    checks++;
    if (ng !== 2) begin errors++; $display("FAIL credit_grants: got %0d expected 2", ng); end
    checks++;
    if (pcx_req !== 1'b0) begin errors++; $display("FAIL credit_block: req=%0d expected 0", pcx_req); end
    pcx_ack = 1'b1;
    pcx_ack_tid = 2'd0;
    tick;
    idle;
    checks++;
    if ({pcx_req, stbcnt0} !== 5'h04) begin errors++; $display("FAIL credit_ack1: req,cnt=%h expected 04", {pcx_req, stbcnt0}); end
    tick;
    checks++;
    if ({pcx_req, pcx_req_tid} !== 3'b100) begin errors++; $display("FAIL credit_ack2: req,tid=%b expected 100", {pcx_req, pcx_req_tid}); end
  endtask

  task automatic test_overflow;
    test_reset;
    stb_alloc = 4'b0010;
    repeat (8) tick;
    stb_alloc = '0;
    checks++;
    if ({stbcnt1, stb_full, stb_err} !== 9'b1000_0010_0) begin errors++; $display("FAIL ovf_fill: cnt=%0d full=%b err=%0d expected 8 0010 0", stbcnt1, stb_full, stb_err); end
    pcx_gnt = 1'b1;
    tick;
    pcx_gnt = 1'b0;
    stb_alloc = 4'b0010;
    pcx_ack = 1'b1;
    pcx_ack_tid = 2'd1;
    tick;
    idle;
    checks++;
    if ({stbcnt1, stb_full, stb_err} !== 9'b1000_0010_0) begin errors++; $display("FAIL ovf_alloc_ack: cnt=%0d full=%b err=%0d expected 8 0010 0", stbcnt1, stb_full, stb_err); end
    stb_alloc = 4'b0010;
    tick;
    idle;
    checks++;
    if ({stbcnt1, stb_err} !== 5'b1000_1) begin errors++; $display("FAIL ovf_alloc: cnt=%0d err=%0d expected 8 1", stbcnt1, stb_err); end
    tick;
    checks++;
    if (stb_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: err=%0d expected 1", stb_err); end
  endtask

  task automatic test_flush;
    test_reset;
    stb_alloc = 4'b1000;
    repeat (6) tick;
    stb_alloc = '0;
    pcx_gnt = 1'b1;
    tick;
    pcx_gnt = 1'b0;
    tick;
    checks++;
    if ({pcx_req, pcx_req_tid, stbcnt3} !== 7'b1_11_0110) begin errors++; $display("FAIL flush_setup: req=%0d tid=%0d cnt=%0d expected 1 3 6", pcx_req, pcx_req_tid, stbcnt3); end
    stb_flush = 4'b1000;
    tick;
    stb_flush = '0;
    checks++;
    if ({pcx_req, stbcnt3} !== 5'b0_0001) begin errors++; $display("FAIL flush_withdraw: req=%0d cnt=%0d expected 0 1", pcx_req, stbcnt3); end
    tick;
    checks++;
    if (pcx_req !== 1'b0) begin errors++; $display("FAIL flush_idle: req=%0d expected 0", pcx_req); end
    pcx_ack = 1'b1;
    pcx_ack_tid = 2'd3;
    tick;
    idle;
    checks++;
    if ({stbcnt3, stb_err} !== 5'b0000_0) begin errors++; $display("FAIL flush_ack: cnt=%0d err=%0d expected 0 0", stbcnt3, stb_err); end
  endtask

  task automatic test_underflow_reset;
    pcx_ack = 1'b1;
    pcx_ack_tid = 2'd0;
    tick;
    idle;
    checks++;
    if ({stb_err, stbcnt0, stbcnt1, stbcnt2, stbcnt3} !== 17'h10000) begin errors++; $display("FAIL underflow: err,cnts=%h expected 10000", {stb_err, stbcnt0, stbcnt1, stbcnt2, stbcnt3}); end
    test_reset;
    stb_alloc = 4'b0011;
    repeat (3) tick;
    pcx_gnt = 1'b1;
    tick;
    checks++;
    if ({stbcnt0, stbcnt1} !== 8'h44) begin errors++; $display("FAIL traffic: cnt0,cnt1=%h expected 44", {stbcnt0, stbcnt1}); end
    rst_l = 1'b0;
    tick;
    rst_l = 1'b1;
    idle;
    checks++;
    if ({pcx_req, pcx_req_tid, stbcnt0, stbcnt1, stbcnt2, stbcnt3, stb_full, stb_err} !== 24'h0) begin
      errors++;
      $display("FAIL mid_reset: outputs=%h expected 0", {pcx_req, pcx_req_tid, stbcnt0, stbcnt1, stbcnt2, stbcnt3, stb_full, stb_err});
    end
    pcx_ack = 1'b1;
    pcx_ack_tid = 2'd0;
    tick;
    idle;
    checks++;
    if ({stb_err, stbcnt0} !== 5'b1_0000) begin errors++; $display("FAIL post_reset_ack: err=%0d cnt=%0d expected 1 0", stb_err, stbcnt0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_credit;
    test_overflow;
    test_flush;
    test_underflow_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
